// File: rtl/grey_pkg.sv
// Shared constants for the grey counter sequencing controller: sizes, state and command codes.
package grey_pkg;
  localparam int DIGITS   = 12;
  localparam int DW       = 5;
  localparam int INIT_W   = DIGITS * DW;
  localparam int BCNT_W   = $clog2(INIT_W);
  localparam int RATE_W   = 8;
  localparam int SCAN_DIV = 4;
  localparam int SDIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DSEL_W   = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_HOLD = 2'b11;
endpackage

// File: rtl/grey_prescale.sv
// Reloadable down-counter; emits a registered one-cycle pulse when an enabled count hits zero.
module grey_prescale
  import grey_pkg::*;
#(
  parameter int W = RATE_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_reload,
  input  logic [W-1:0] i_rate,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  logic         r_zero;

  // Reload wins over counting; the pulse also reloads so the period is i_rate+1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_zero <= 1'b0;
    end else begin
      r_zero <= 1'b0;
      if (i_reload) begin
        r_cnt <= i_rate;
      end else if (i_en) begin
        if (r_cnt == '0) begin
          r_zero <= 1'b1;
          r_cnt  <= i_rate;
        end else begin
          r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign o_zero = r_zero;
endmodule

// File: rtl/grey_seq_ctrl.sv
// Sequencing controller for the 12-digit grey counter: serial init load, prescaled run/hold
// enable and free-running digit-select scan.
module grey_seq_ctrl
  import grey_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_cmd,
  input  logic              i_cmd_vld,
  input  logic              i_sdata,
  input  logic              i_sdata_vld,
  input  logic [RATE_W-1:0] i_rate,
  output logic [INIT_W-1:0] o_init,
  output logic              o_load,
  output logic              o_en,
  output logic [3:0]        o_dsel,
  output logic [1:0]        o_state,
  output logic              o_err
);
  // Both inputs are valid-only streams: no ready, a beat is taken on every cycle its valid is high.
  logic [1:0]        r_state;
  logic [INIT_W-1:0] r_init;
  logic [BCNT_W-1:0] r_bcnt;
  logic              r_load;
  logic              r_err;
  logic [SDIV_W-1:0] r_sdiv;
  logic [DSEL_W-1:0] r_dsel;

  logic       w_cmd_load, w_cmd_run, w_cmd_hold;
  logic       w_shift, w_last_bit;
  logic [1:0] w_state_nxt;
  logic       w_err_set, w_load_acc, w_pre_reload, w_pre_en, w_en;

  always_comb begin
    w_cmd_load = 1'b0;
    w_cmd_run  = 1'b0;
    w_cmd_hold = 1'b0;
    if (i_cmd_vld) begin
      case (i_cmd)
        CMD_NOP:  ;
        CMD_LOAD: w_cmd_load = 1'b1;
        CMD_RUN:  w_cmd_run  = 1'b1;
        CMD_HOLD: w_cmd_hold = 1'b1;
      endcase
    end
  end

  assign w_shift    = (r_state == ST_SHIFT) && i_sdata_vld;
  assign w_last_bit = w_shift && (r_bcnt == BCNT_W'(INIT_W - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_err_set    = 1'b0;
    w_load_acc   = 1'b0;
    w_pre_reload = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_load) begin
          w_state_nxt = ST_SHIFT;
          w_load_acc  = 1'b1;
        end else if (w_cmd_run) begin
          w_state_nxt  = ST_RUN;
          w_pre_reload = 1'b1;
        end else if (w_cmd_hold) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_SHIFT: begin
        // A completing bit beats any command; that command is reported as rejected.
        if (w_last_bit) begin
          w_state_nxt = ST_IDLE;
          w_err_set   = w_cmd_load | w_cmd_run | w_cmd_hold;
        end else if (w_cmd_hold) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cmd_load || w_cmd_run) begin
          w_err_set = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_cmd_hold) begin
          w_state_nxt = ST_HOLD;
        end else if (w_cmd_load) begin
          w_state_nxt = ST_SHIFT;
          w_load_acc  = 1'b1;
        end
      end
      default: begin
        if (w_cmd_run) begin
          w_state_nxt  = ST_RUN;
          w_pre_reload = 1'b1;
        end else if (w_cmd_load) begin
          w_state_nxt = ST_SHIFT;
          w_load_acc  = 1'b1;
        end
      end
    endcase
  end

  // Leaving RUN suppresses the pulse on that edge so o_en drops immediately.
  assign w_pre_en = (r_state == ST_RUN) && !w_cmd_hold && !w_cmd_load;

  grey_prescale #(.W(RATE_W)) u_prescale (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_pre_en),
    .i_reload (w_pre_reload),
    .i_rate   (i_rate),
    .o_zero   (w_en)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_init  <= '0;
      r_bcnt  <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= w_last_bit;
      if (w_shift) r_init <= {r_init[INIT_W-2:0], i_sdata};
      if (w_load_acc) r_bcnt <= '0;
      else if (w_shift) r_bcnt <= r_bcnt + BCNT_W'(1);
      if (w_load_acc) r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sdiv <= '0;
      r_dsel <= '0;
    end else if (r_sdiv == SDIV_W'(SCAN_DIV - 1)) begin
      r_sdiv <= '0;
      r_dsel <= (r_dsel == DSEL_W'(DIGITS - 1)) ? '0 : r_dsel + DSEL_W'(1);
    end else begin
      r_sdiv <= r_sdiv + SDIV_W'(1);
    end
  end

  assign o_init  = r_init;
  assign o_load  = r_load;
  assign o_en    = w_en;
  assign o_dsel  = r_dsel;
  assign o_state = r_state;
  assign o_err   = r_err;
endmodule
